// File: rtl/ff_pkg.sv
// Shared types for the skid buffer: controller state encoding and occupancy codes.
package ff_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_BUSY  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/dff_sync_rst_n.sv
// Enable-gated register with synchronous active-low clear.
module dff_sync_rst_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buffer_sync_rst_n.sv
// Two-entry valid/ready skid buffer; in_ready is a flop so upstream never sees
// a combinational path from out_ready.
module skid_buffer_sync_rst_n
    import ff_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;
    assign in_ready = in_ready_q;
    assign out_data = main_q;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Flush wins over any load: a beat arriving in the flush cycle is dropped.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_en = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_en = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        case (state_q)
            BUSY:    occupancy = OCC_BUSY;
            FULL:    occupancy = OCC_FULL;
            default: occupancy = OCC_EMPTY;
        endcase
    end

    dff_sync_rst_n #(.WIDTH(WIDTH)) u_main (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .en         (main_en),
        .d          (main_d),
        .q          (main_q)
    );

    dff_sync_rst_n #(.WIDTH(WIDTH)) u_skid (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .en         (skid_en),
        .d          (in_data),
        .q          (skid_q)
    );

endmodule

// File: tb/tb_skid_buffer_sync_rst_n.sv
// Bench for skid_buffer_sync_rst_n: queue-based reference model plus directed and random traffic.
module tb_skid_buffer_sync_rst_n;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         sync_rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    skid_buffer_sync_rst_n #(.WIDTH(W)) dut (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two beats and the ready flag upstream will see.
    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    bit           m_rdy = 1'b0;
    bit           chk_en = 1'b0;
    int           n_in = 0;
    int           n_out = 0;

    always @(posedge clk) begin
        bit fin;
        bit fout;
        if (!sync_rst_n) begin
            mq.delete();
            m_rdy = 1'b0;
        end else begin
            fin  = in_valid && m_rdy;
            fout = (mq.size() > 0) && out_ready;
            if (fout) begin
                got.push_back(mq.pop_front());
                n_out++;
            end
            if (flush) mq.delete();
            else if (fin) begin
                mq.push_back(in_data);
                n_in++;
            end
            m_rdy = (mq.size() < 2);
        end
        chk_en = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_valid", int'(out_valid), int'(mq.size() > 0));
            check("model_occupancy", int'(occupancy), mq.size());
            check("model_in_ready", int'(in_ready), int'(m_rdy));
            if (mq.size() > 0) check("model_out_data", int'(out_data), int'(mq[0]));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        bit ir;
        sync_rst_n = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h0F;
        out_ready  = 1'b0;

        // Reset held for three edges with a valid beat waiting.
        repeat (3) step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_occupancy", int'(occupancy), 0);
        sync_rst_n = 1'b1;
        step();
        check("release_in_ready", int'(in_ready), 1);
        check("release_no_capture", int'(out_valid), 0);
        in_valid = 1'b0;
        step();

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
            check("stream_data", int'(out_data), i);
            check("stream_occ", int'(occupancy), 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", int'(out_valid), 0);

        // Back-pressure fills the skid entry, then drains in order.
        got.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0A; step();
        in_data   = 8'h0B; step();
        in_data   = 8'h0C; step();
        check("bp_occ", int'(occupancy), 2);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_data", int'(out_data), 8'h0A);
        step();
        check("bp_data_stable", int'(out_data), 8'h0A);
        out_ready = 1'b1;
        step();
        check("bp_drain_b", int'(out_data), 8'h0B);
        step();
        check("bp_drain_c", int'(out_data), 8'h0C);
        in_valid = 1'b0;
        step();
        check("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            check("bp_first", int'(got[0]), 8'h0A);
            check("bp_second", int'(got[1]), 8'h0B);
            check("bp_third", int'(got[2]), 8'h0C);
        end

        // Flush while full with a beat offered in the flush cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01; step();
        in_data   = 8'h02; step();
        check("pre_flush_occ", int'(occupancy), 2);
        got.delete();
        in_data = 8'h03;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_occ", int'(occupancy), 0);
        check("flush_in_ready", int'(in_ready), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("flush_nothing_out", got.size(), 0);

        // Reset while full, then a fresh beat.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h07; step();
        in_data   = 8'h08; step();
        check("pre_rst_occ", int'(occupancy), 2);
        sync_rst_n = 1'b0;
        step();
        sync_rst_n = 1'b1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_occ", int'(occupancy), 0);
        check("midrst_out_data", int'(out_data), 0);
        in_data = 8'h05;
        step();
        check("post_rst_ready", int'(in_ready), 1);
        step();
        check("fresh_valid", int'(out_valid), 1);
        check("fresh_data", int'(out_data), 8'h05);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Random traffic until 10k beats have been accepted.
        n_in  = 0;
        n_out = 0;
        cyc   = 0;
        while (n_in < 10000 && cyc < 80000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 3);
            if (cyc % 64 == 0) begin
                #1;
                ir        = in_ready;
                out_ready = ~out_ready;
                in_valid  = ~in_valid;
                #1;
                check("ready_independent", int'(in_ready), int'(ir));
                out_ready = ~out_ready;
                in_valid  = ~in_valid;
            end
            step();
            cyc++;
        end
        check("random_budget", int'(n_in >= 10000), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("random_all_delivered", n_out, n_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
